// File: rtl/stamp2bcd_time.sv
// -----------------------------------------------------------------------------
// stamp2bcd_time
// Converts a seconds count since 2000-01-01 00:00:00 into calendar fields
// (year, month, day, hour, minute, second) as BCD digits. The conversion is
// sequential: a 32-cycle restoring division by 86400 splits days from
// seconds-of-day, then subtractive loops peel off hours, minutes, years and
// months one per cycle. Requests of 100 years or more are rejected with
// range_err.
//
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset
//   start      - request a conversion of stamp (taken only when idle)
//   stamp      - 64-bit seconds since 2000-01-01 00:00:00
//   busy       - conversion in progress
//   done       - one-cycle pulse, result or error valid
//   range_err  - last request was out of range (held until next done)
//   year_bcd   - four BCD digits, always 20xx
//   month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd - two BCD digits each
// -----------------------------------------------------------------------------
module stamp2bcd_time (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] stamp,
    output logic        busy,
    output logic        done,
    output logic        range_err,
    output logic [15:0] year_bcd,
    output logic [7:0]  month_bcd,
    output logic [7:0]  day_bcd,
    output logic [7:0]  hour_bcd,
    output logic [7:0]  minute_bcd,
    output logic [7:0]  second_bcd
);

    // 36525 days * 86400 s: first stamp beyond 2099-12-31 23:59:59
    localparam logic [63:0] STAMP_LIMIT = 64'd3155760000;
    localparam logic [17:0] SEC_PER_DAY = 18'd86400;

    typedef enum logic [2:0] {
        S_IDLE, S_DIV, S_HOUR, S_MIN, S_YEAR, S_MONTH, S_FIN
    } state_t;

    // Double-dabble conversion of a value below 100 into two BCD digits.
    function automatic logic [7:0] bin2bcd8(input logic [6:0] v);
        logic [14:0] sh;
        sh = {8'd0, v};
        for (int i = 0; i < 7; i++) begin
            sh[10:7]  = (sh[10:7]  >= 4'd5) ? sh[10:7]  + 4'd3 : sh[10:7];
            sh[14:11] = (sh[14:11] >= 4'd5) ? sh[14:11] + 4'd3 : sh[14:11];
            sh        = {sh[13:0], 1'b0};
        end
        return sh[14:7];
    endfunction

    // Days in a month (1..12); February depends on the leap flag.
    function automatic logic [15:0] month_len(input logic [3:0] m, input logic leap);
        logic [15:0] len;
        case (m)
            4'd2:                    len = leap ? 16'd29 : 16'd28;
            4'd4, 4'd6, 4'd9, 4'd11: len = 16'd30;
            default:                 len = 16'd31;
        endcase
        return len;
    endfunction

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_acc;       // dividend/quotient during DIV, remaining days after
    logic [16:0] r_rem;       // division remainder, then seconds left in the day
    logic [4:0]  r_hour;
    logic [5:0]  r_min;
    logic [6:0]  r_year_off;  // years past 2000
    logic [3:0]  r_month;
    logic        r_err_pend;  // out-of-range request seen, report on next cycle

    logic [17:0] w_trial;
    logic        w_div_ge;
    logic [17:0] w_div_rem;
    logic        w_leap;
    logic [15:0] w_ylen;
    logic [15:0] w_mlen;

    // Division step and year/month length lookup for the current iteration.
    always_comb begin
        w_trial   = {r_rem, r_acc[31]};
        w_div_ge  = (w_trial >= SEC_PER_DAY);
        w_div_rem = w_div_ge ? (w_trial - SEC_PER_DAY) : w_trial;
        // Every 4th year is leap across 2000..2099 (2000 itself is leap).
        w_leap    = (r_year_off[1:0] == 2'd0);
        w_ylen    = w_leap ? 16'd366 : 16'd365;
        w_mlen    = month_len(r_month, w_leap);
    end

    // Conversion FSM with registered status and BCD outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_acc      <= 32'd0;
            r_rem      <= 17'd0;
            r_hour     <= 5'd0;
            r_min      <= 6'd0;
            r_year_off <= 7'd0;
            r_month    <= 4'd1;
            r_err_pend <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            range_err  <= 1'b0;
            year_bcd   <= 16'h2000;
            month_bcd  <= 8'h01;
            day_bcd    <= 8'h01;
            hour_bcd   <= 8'h00;
            minute_bcd <= 8'h00;
            second_bcd <= 8'h00;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_err_pend) begin
                        // Error report takes this cycle; a start here is dropped.
                        r_err_pend <= 1'b0;
                        done       <= 1'b1;
                        range_err  <= 1'b1;
                    end else if (start) begin
                        if (stamp < STAMP_LIMIT) begin
                            r_acc      <= stamp[31:0];
                            r_rem      <= 17'd0;
                            r_cnt      <= 5'd0;
                            r_hour     <= 5'd0;
                            r_min      <= 6'd0;
                            r_year_off <= 7'd0;
                            r_month    <= 4'd1;
                            busy       <= 1'b1;
                            r_state    <= S_DIV;
                        end else begin
                            r_err_pend <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DIV: begin
                    r_acc <= {r_acc[30:0], w_div_ge};
                    r_rem <= w_div_rem[16:0];
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_HOUR;
                    end else begin
                        r_state <= S_DIV;
                    end
                end
                S_HOUR: begin
                    if (r_rem >= 17'd3600) begin
                        r_rem  <= r_rem - 17'd3600;
                        r_hour <= r_hour + 5'd1;
                    end else begin
                        r_state <= S_MIN;
                    end
                end
                S_MIN: begin
                    if (r_rem >= 17'd60) begin
                        r_rem <= r_rem - 17'd60;
                        r_min <= r_min + 6'd1;
                    end else begin
                        r_state <= S_YEAR;
                    end
                end
                S_YEAR: begin
                    if (r_acc[15:0] >= w_ylen) begin
                        r_acc[15:0] <= r_acc[15:0] - w_ylen;
                        r_year_off  <= r_year_off + 7'd1;
                    end else begin
                        r_state <= S_MONTH;
                    end
                end
                S_MONTH: begin
                    if (r_acc[15:0] >= w_mlen) begin
                        r_acc[15:0] <= r_acc[15:0] - w_mlen;
                        r_month     <= r_month + 4'd1;
                    end else begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    year_bcd   <= {8'h20, bin2bcd8(r_year_off)};
                    month_bcd  <= bin2bcd8({3'd0, r_month});
                    day_bcd    <= bin2bcd8(r_acc[6:0] + 7'd1);
                    hour_bcd   <= bin2bcd8({2'd0, r_hour});
                    minute_bcd <= bin2bcd8({1'b0, r_min});
                    second_bcd <= bin2bcd8(r_rem[6:0]);
                    range_err  <= 1'b0;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stamp2bcd_time.sv
// -----------------------------------------------------------------------------
// tb_stamp2bcd_time
// Directed bench for stamp2bcd_time: hand-computed calendar results and
// latencies for known stamps, range error, busy-time start, and reset
// mid-conversion.
// -----------------------------------------------------------------------------
module tb_stamp2bcd_time;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] stamp;
    logic        busy;
    logic        done;
    logic        range_err;
    logic [15:0] year_bcd;
    logic [7:0]  month_bcd;
    logic [7:0]  day_bcd;
    logic [7:0]  hour_bcd;
    logic [7:0]  minute_bcd;
    logic [7:0]  second_bcd;

    int n_tests = 0;
    int n_fail  = 0;

    stamp2bcd_time dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stamp      (stamp),
        .busy       (busy),
        .done       (done),
        .range_err  (range_err),
        .year_bcd   (year_bcd),
        .month_bcd  (month_bcd),
        .day_bcd    (day_bcd),
        .hour_bcd   (hour_bcd),
        .minute_bcd (minute_bcd),
        .second_bcd (second_bcd)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request (start sampled at edge N), wait for done, check
    // latency and all fields. poke_at > 0 pulses start again while busy.
    task automatic run_conv(input string tag, input logic [63:0] s, input int exp_lat,
                            input logic exp_err, input logic [15:0] ey,
                            input logic [7:0] emo, input logic [7:0] ed,
                            input logic [7:0] eh, input logic [7:0] emi,
                            input logic [7:0] es, input int poke_at);
        logic [55:0] snap;
        logic        got;
        logic        unstable;
        int          edges;
        @(negedge clk);
        snap     = {year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd};
        stamp    = s;
        start    = 1'b1;
        got      = 1'b0;
        unstable = 1'b0;
        edges    = 0;
        @(posedge clk);
        #1 start = 1'b0;
        while (!got && edges < 400) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1 && exp_lat > 1) chk({tag, "/busy_on"}, busy, 1'b1);
            if (done) begin
                got = 1'b1;
            end else begin
                if ({year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd} !== snap)
                    unstable = 1'b1;
                if (edges == poke_at) begin
                    start = 1'b1;
                    stamp = 64'd0;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk({tag, "/done_seen"}, got, 1'b1);
        chk({tag, "/latency"}, edges, exp_lat);
        chk({tag, "/stable"}, unstable, 1'b0);
        chk({tag, "/busy_at_done"}, busy, 1'b0);
        chk({tag, "/range_err"}, range_err, exp_err);
        chk({tag, "/year"}, year_bcd, ey);
        chk({tag, "/month"}, month_bcd, emo);
        chk({tag, "/day"}, day_bcd, ed);
        chk({tag, "/hour"}, hour_bcd, eh);
        chk({tag, "/minute"}, minute_bcd, emi);
        chk({tag, "/second"}, second_bcd, es);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "/busy"}, busy, 1'b0);
        chk({tag, "/done"}, done, 1'b0);
        chk({tag, "/range_err"}, range_err, 1'b0);
        chk({tag, "/year"}, year_bcd, 16'h2000);
        chk({tag, "/month"}, month_bcd, 8'h01);
        chk({tag, "/day"}, day_bcd, 8'h01);
        chk({tag, "/hms"}, {hour_bcd, minute_bcd, second_bcd}, 24'h000000);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk({tag, "/no_done"}, seen, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stamp = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_done("after_por", 5);

        // Epoch origin: 37-cycle minimum latency.
        run_conv("zero", 64'd0, 37, 1'b0, 16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        // Last second of the first day: 23 hour and 59 minute iterations.
        run_conv("eod", 64'd86399, 119, 1'b0, 16'h2000, 8'h01, 8'h01, 8'h23, 8'h59, 8'h59, 0);
        // Leap February 29th at noon.
        run_conv("feb29", 64'd5140800, 50, 1'b0, 16'h2000, 8'h02, 8'h29, 8'h12, 8'h00, 8'h00, 0);
        // Year 2000 rollover boundary.
        run_conv("eoy2000", 64'd31622399, 130, 1'b0, 16'h2000, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 0);
        run_conv("ny2001", 64'd31622400, 38, 1'b0, 16'h2001, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        // Largest accepted stamp.
        run_conv("max", 64'd3155759999, 229, 1'b0, 16'h2099, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 0);
        // First rejected stamp: outputs keep the previous result.
        run_conv("over", 64'd3155760000, 1, 1'b1, 16'h2099, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 0);
        // Good result after an error clears range_err.
        run_conv("clear", 64'd0, 37, 1'b0, 16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        // Start pulsed while busy is ignored.
        run_conv("busy_ign", 64'd86399, 119, 1'b0, 16'h2000, 8'h01, 8'h01, 8'h23, 8'h59, 8'h59, 5);
        watch_no_done("after_busy_ign", 10);

        // Reset in the middle of the division.
        @(negedge clk);
        stamp = 64'd86399;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_done("after_mid_rst", 150);
        run_conv("recover", 64'd86399, 119, 1'b0, 16'h2000, 8'h01, 8'h01, 8'h23, 8'h59, 8'h59, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
